add16_rr_arbiter: RTL
=====================

# add16_rr_arbiter

Round-robin arbiter and sequencer that shares a single 16-bit carry-in adder between NREQ requesters. It sits in front of the 16-bit adder datapath. It accepts one add request per cycle over valid/ready handshakes and registers the 17-bit result with the winner's ID. It also supports multi-word (wider-than-16-bit) additions: the adder stays locked to one requester and carry is chained between words.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, operand width (fixed to the adder width)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; a word transfers when valid and ready are both high
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_cin  in  NREQ  carry-in; used only on the first word of an operation
- req_more  in  NREQ  1 = further words of this operation follow (hold grant, chain carry)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer accept
- rsp_id  out  $clog2(NREQ)  index of the requester that produced this result
- rsp_sum  out  W  sum bits
- rsp_cout  out  1  carry-out
- rsp_last  out  1  copy of ~req_more for this word

## Operation
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin_eff, computed at full 17-bit width with no truncation.
- cin_eff = req_cin in IDLE; cin_eff = carry_q in LOCKED.
- States:
  - IDLE: arbitrate among all requesters.
  - LOCKED(owner, carry_q): only the owner is eligible.
- Arbitration in IDLE: grant the first requester with req_valid=1, scanning from ptr upward and wrapping modulo NREQ.
- slot_free = ~rsp_valid | rsp_ready.
- req_ready[i] = grant[i] & slot_free. At most one bit of req_ready is high.
  - req_ready may depend combinationally on req_valid.
  - Requesters must not derive valid from ready.
- On a transfer with more=1:
  - go to (or stay in) LOCKED.
  - owner = granted index.
  - carry_q = cout of this word.
- On a transfer with more=0:
  - go to IDLE.
  - ptr = (granted index + 1) mod NREQ.
- If the owner drops valid while LOCKED, the block stalls. No timeout. Other requesters get req_ready=0 throughout.
- Output register holds one entry.
  - It loads on every transfer.
  - It clears rsp_valid when rsp_ready=1 and no new transfer occurs.
  - rsp_* fields are stable while rsp_valid=1 and rsp_ready=0.

## Timing
- Latency: a word accepted in cycle N appears with rsp_valid=1 in cycle N+1.
- Throughput: one word per cycle while rsp_ready=1.
- Simultaneous rsp_ready=1 and a new transfer: the old result retires and the new one loads in the same edge. No bubble.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_last=0
  - state=IDLE, ptr=0, carry_q=0, owner=0
  - req_ready follows combinationally from this state.
- Reset mid-operation aborts any lock and discards the pending result. The requester must restart the whole multi-word operation.
- ptr advances only on the last word of an operation, never on stalled cycles.
- Wrap-around: ptr = NREQ-1 followed by a last word returns ptr to 0.

## Structure
- Package add16_arb_pkg holds:
  - the W constant
  - the default NREQ
  - the state enum {IDLE, LOCKED}
- Sub-module add16_core: purely combinational 16-bit adder with carry-in, 17-bit result. It is instantiated once, with operands muxed by grant.
- The arbiter FSM, ptr, carry_q and the output register live in the top block.

## Test plan
- Single word: req0 a=0xFFFF, b=0x0001, cin=0, more=0 -> next cycle rsp_valid=1, id=0, sum=0x0000, cout=1, last=1.
- Carry-in: req3 a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, id=3.
- Fairness: all four valid continuously, more=0, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1, one per cycle, no gaps.
- Chained 32-bit add:
  - Stimulus: req2 adds 0x0001_FFFF + 0x0000_0001 as two words (low word first, more=1; then high word, more=0), with req1 valid throughout.
  - Responses: sum 0x0000 with cout=1, then sum 0x0002 with cout=0 and last=1.
  - Arbitration: req1 is not granted until the cycle after the last word; ptr=3, so req1 wins next.
- Backpressure: hold rsp_ready=0 while rsp_valid=1 -> all req_ready=0 and rsp_* stable for 5 cycles. Raise rsp_ready -> the held result retires and the next word is accepted in the same cycle.
- Reset mid-burst: assert rst while LOCKED to req1 -> next cycle rsp_valid=0 and state IDLE. With req0 and req1 both valid after reset, req0 is granted first (ptr=0).

Source files
------------

// File: rtl/add16_arb_pkg.sv
// Shared constants and types for the round-robin arbiter in front of the
// 16-bit carry-in adder.
package add16_arb_pkg;

    localparam int W            = 16;
    localparam int NREQ_DEFAULT = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage : add16_arb_pkg

// File: rtl/add16_core.sv
// Purely combinational W-bit adder with carry-in; the carry-out is the MSB
// of the (W+1)-bit result.
module add16_core
    import add16_arb_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W:0]   sum_o
);

    assign sum_o = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule : add16_core

// File: rtl/add16_rr_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters, with a
// one-entry result register and carry chaining for multi-word operations.
module add16_rr_arbiter
    import add16_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*W-1:0]         req_a,
    input  logic [NREQ*W-1:0]         req_b,
    input  logic [NREQ-1:0]           req_cin,
    input  logic [NREQ-1:0]           req_more,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [W-1:0]              rsp_sum,
    output logic                      rsp_cout,
    output logic                      rsp_last
);

    localparam int IDW = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic             carry_q, carry_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [W-1:0]     rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_last_q, rsp_last_d;

    logic             found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic [NREQ-1:0]  grant;
    logic             slot_free;
    logic             xfer;
    logic [W-1:0]     op_a, op_b;
    logic             cin_eff;
    logic             more_sel;
    logic [W:0]       add_res;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state_q == LOCKED) begin
            grant_idx = owner_q;
            found     = req_valid[owner_q];
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = IDW'((int'(ptr_q) + k) % NREQ);
                if (!found && req_valid[cand]) begin
                    found     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        op_a     = '0;
        op_b     = '0;
        more_sel = 1'b0;
        cin_eff  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                op_a     = req_a[k*W +: W];
                op_b     = req_b[k*W +: W];
                more_sel = req_more[k];
                cin_eff  = req_cin[k];
            end
        end
        // Later words of a locked operation take the chained carry instead.
        if (state_q == LOCKED) begin
            cin_eff = carry_q;
        end
    end

    add16_core u_core (
        .a_i   (op_a),
        .b_i   (op_b),
        .cin_i (cin_eff),
        .sum_o (add_res)
    );

    always_comb begin
        grant = '0;
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign slot_free = ~rsp_valid_q | rsp_ready;
    assign req_ready = grant & {NREQ{slot_free}};
    assign xfer      = found & slot_free;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_last_d  = rsp_last_q;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_sum_d   = add_res[W-1:0];
            rsp_cout_d  = add_res[W];
            rsp_last_d  = ~more_sel;
            if (more_sel) begin
                state_d = LOCKED;
                owner_d = grant_idx;
                carry_d = add_res[W];
            end else begin
                state_d = IDLE;
                carry_d = 1'b0;
                ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_last  = rsp_last_q;

endmodule : add16_rr_arbiter
